// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: project-select controller for the project multiplexer.
// Synchronizes the select-reset, select-increment and enable pins, keeps a
// wrapping project address and only raises ena once the address has been
// valid and stable for SETTLE_CYC cycles.
// Optional feature macro: MUX_SEL_LOAD_EN adds a synchronous parallel load
// (load_en / load_addr) between the clear and increment priorities.
module mux_sel_ctrl #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned NUM_PROJ    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel_rst_n,
    input  logic              sel_inc,
    input  logic              ena_in,
`ifdef MUX_SEL_LOAD_EN
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic              ena,
    output logic              sel_valid
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {StOff, StSettle, StOn} state_e;

    logic [SYNC_STAGES-1:0] rst_n_sync_q;
    logic [SYNC_STAGES-1:0] inc_sync_q;
    logic [SYNC_STAGES-1:0] ena_sync_q;
    logic                   sync_rst_n;
    logic                   sync_inc;
    logic                   sync_ena;
    logic                   inc_q;
    logic                   inc_evt;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sel_valid_q, sel_valid_d;
    logic              addr_chg;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ena_q;

    // Pin synchronizers; the select-reset chain idles high so reset does not clear twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_n_sync_q <= '1;
            inc_sync_q   <= '0;
            ena_sync_q   <= '0;
            inc_q        <= 1'b0;
        end else begin
            rst_n_sync_q <= {rst_n_sync_q[SYNC_STAGES-2:0], sel_rst_n};
            inc_sync_q   <= {inc_sync_q[SYNC_STAGES-2:0], sel_inc};
            ena_sync_q   <= {ena_sync_q[SYNC_STAGES-2:0], ena_in};
            inc_q        <= inc_sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_rst_n = rst_n_sync_q[SYNC_STAGES-1];
    assign sync_inc   = inc_sync_q[SYNC_STAGES-1];
    assign sync_ena   = ena_sync_q[SYNC_STAGES-1];
    assign inc_evt    = sync_inc & ~inc_q;

    // Next address: clear beats load beats increment; a discarded increment is not replayed.
    always_comb begin
        addr_d = addr_q;
        if (!sync_rst_n) begin
            addr_d = '0;
        end
`ifdef MUX_SEL_LOAD_EN
        else if (load_en) begin
            addr_d = load_addr;
        end
`endif
        else if (inc_evt) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        addr_chg    = (addr_d != addr_q);
        sel_valid_d = (32'(addr_d) < NUM_PROJ);
    end

    // Enable FSM; decoding from the next address lets ena drop on the same edge addr moves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StOff: begin
                if (sync_ena && sel_valid_q && !addr_chg) begin
                    state_d = StSettle;
                    cnt_d   = CNT_W'(SETTLE_CYC);
                end
            end
            StSettle: begin
                // Losing the request or validity wins over a settle restart.
                if (!sync_ena || !sel_valid_q) begin
                    state_d = StOff;
                end else if (addr_chg) begin
                    cnt_d = CNT_W'(SETTLE_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StOn;
                    end
                end
            end
            StOn: begin
                if (!sync_ena || !sel_valid_q) begin
                    state_d = StOff;
                end else if (addr_chg) begin
                    state_d = StSettle;
                    cnt_d   = CNT_W'(SETTLE_CYC);
                end
            end
            default: begin
                state_d = StOff;
            end
        endcase
    end

    // Output and FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            sel_valid_q <= 1'b1;
            state_q     <= StOff;
            cnt_q       <= '0;
            ena_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            sel_valid_q <= sel_valid_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ena_q       <= (state_d == StOn);
        end
    end

    assign addr      = addr_q;
    assign sel_valid = sel_valid_q;
    assign ena       = ena_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Bench for mux_sel_ctrl: directed scenarios with literal expectations plus
// random pin activity, all checked every cycle against a timestamp-based model.
module tb_mux_sel_ctrl;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_PROJ = 16;
    localparam int unsigned SS = 2;
    localparam int unsigned SETTLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel_rst_n = 1'b1;
    logic sel_inc = 1'b0;
    logic ena_in = 1'b0;
    logic load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [ADDR_W-1:0] addr;
    logic ena;
    logic sel_valid;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    mux_sel_ctrl #(
        .ADDR_W(ADDR_W),
        .NUM_PROJ(NUM_PROJ),
        .SYNC_STAGES(SS),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sel_rst_n(sel_rst_n),
        .sel_inc(sel_inc),
        .ena_in(ena_in),
`ifdef MUX_SEL_LOAD_EN
        .load_en(load_en),
        .load_addr(load_addr),
`endif
        .addr(addr),
        .ena(ena),
        .sel_valid(sel_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pin histories give the synchronized view; ena is decided from
    // timestamps (when the request became continuously good, when addr last moved).
    bit rh[0:SS];
    bit ih[0:SS];
    bit eh[0:SS];
    int k;
    int m_start;
    int m_lastchg;
    bit m_active;
    bit m_ena;
    int m_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= SS; i++) begin
                rh[i] = 1'b1;
                ih[i] = 1'b0;
                eh[i] = 1'b0;
            end
            k = 0;
            m_start = -1000;
            m_lastchg = -1000;
            m_active = 1'b0;
            m_ena = 1'b0;
            m_addr = 0;
        end else begin
            int nxt;
            bit chg;
            bit good;
            k++;
            nxt = m_addr;
            if (!rh[SS-1]) nxt = 0;
`ifdef MUX_SEL_LOAD_EN
            else if (load_en) nxt = int'(load_addr);
`endif
            else if (ih[SS-1] && !ih[SS]) nxt = (m_addr + 1) % (1 << ADDR_W);
            chg = (nxt != m_addr);
            good = eh[SS-1] && (m_addr < NUM_PROJ);
            if (good && !m_active && !chg) m_start = k;
            m_active = good && (m_active || !chg);
            if (chg) m_lastchg = k;
            m_addr = nxt;
            m_ena = m_active && (k - m_start >= SETTLE) && (k - m_lastchg >= SETTLE);
            for (int i = SS; i > 0; i--) begin
                rh[i] = rh[i-1];
                ih[i] = ih[i-1];
                eh[i] = eh[i-1];
            end
            rh[0] = sel_rst_n;
            ih[0] = sel_inc;
            eh[0] = ena_in;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on && !rst) begin
            check("addr_vs_model", 32'(addr), 32'(m_addr));
            check("ena_vs_model", 32'(ena), 32'(m_ena));
            check("valid_vs_model", 32'(sel_valid), 32'(m_addr < NUM_PROJ));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            sel_inc = 1'b1;
            cyc(4);
            sel_inc = 1'b0;
            cyc(4);
        end
    endtask

    task automatic clear_addr();
        sel_rst_n = 1'b0;
        cyc(4);
        sel_rst_n = 1'b1;
        cyc(4);
    endtask

    initial begin
        cyc(2);
        check("reset_addr", 32'(addr), 0);
        check("reset_ena", 32'(ena), 0);
        check("reset_valid", 32'(sel_valid), 1);

        // Enable from cycle 0: ena rises on edge 7.
        rst = 1'b0;
        ena_in = 1'b1;
        cmp_on = 1'b1;
        cyc(6);
        check("ena_low_edge6", 32'(ena), 0);
        cyc(1);
        check("ena_high_edge7", 32'(ena), 1);
        check("addr_zero", 32'(addr), 0);

        // Five slow increments.
        pulses(5);
        cyc(2);
        check("addr_after5", 32'(addr), 5);
        check("ena_after5", 32'(ena), 1);

        // Run past the populated range, then wrap.
        clear_addr();
        pulses(16);
        cyc(4);
        check("addr_16", 32'(addr), 16);
        check("valid_16", 32'(sel_valid), 0);
        check("ena_16", 32'(ena), 0);
        pulses(16);
        cyc(8);
        check("addr_wrap", 32'(addr), 0);
        check("valid_wrap", 32'(sel_valid), 1);
        check("ena_wrap", 32'(ena), 1);

        // Clear together with an increment edge: increment is dropped.
        pulses(9);
        cyc(4);
        check("addr_9", 32'(addr), 9);
        sel_rst_n = 1'b0;
        sel_inc = 1'b1;
        cyc(4);
        sel_rst_n = 1'b1;
        cyc(6);
        sel_inc = 1'b0;
        cyc(6);
        check("addr_clr_no_inc", 32'(addr), 0);

        // Asynchronous reset while on at 7.
        pulses(7);
        cyc(8);
        check("addr_7", 32'(addr), 7);
        check("ena_on_7", 32'(ena), 1);
        #2 rst = 1'b1;
        #1;
        check("async_addr", 32'(addr), 0);
        check("async_ena", 32'(ena), 0);
        check("async_valid", 32'(sel_valid), 1);
        cyc(2);
        rst = 1'b0;
        cyc(10);

`ifdef MUX_SEL_LOAD_EN
        pulses(3);
        cyc(8);
        check("ena_on_3", 32'(ena), 1);
        load_en = 1'b1;
        load_addr = 5'd12;
        cyc(1);
        load_en = 1'b0;
        check("load_12", 32'(addr), 12);
        check("load_ena_drop", 32'(ena), 0);
        cyc(3);
        check("load_ena_wait", 32'(ena), 0);
        cyc(1);
        check("load_ena_back", 32'(ena), 1);
        load_en = 1'b1;
        load_addr = 5'd20;
        cyc(1);
        load_en = 1'b0;
        check("load_20", 32'(addr), 20);
        cyc(6);
        check("load_20_valid", 32'(sel_valid), 0);
        check("load_20_ena", 32'(ena), 0);
`endif

        // Random pin activity, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) sel_inc = ~sel_inc;
            if ($urandom_range(0, 39) == 0) ena_in = ~ena_in;
            if (sel_rst_n) begin
                if ($urandom_range(0, 79) == 0) sel_rst_n = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                sel_rst_n = 1'b1;
            end
`ifdef MUX_SEL_LOAD_EN
            load_en = ($urandom_range(0, 29) == 0);
            load_addr = ADDR_W'($urandom_range(0, 20));
`endif
            cyc(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
